iq_cic_decim: RTL and testbench

- Dual-channel, third-order CIC decimator. Consumes the I/Q mixer products (o_signal_i/o_signal_q of the IQ generator) and produces decimated, scaled, saturated baseband I/Q samples.
- Both channels share one control path: sample counter, ratio/shift latch and output strobe.
- Sits directly downstream of the IQ generator, clocked by the same i_clk/i_ce.

---
 rtl/iq_cic_decim.sv | 216 +++++++++++++++++++++
 tb/tb_iq_cic_decim.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_cic_decim.sv
// iq_cic_decim: dual-channel (I/Q) third-order CIC decimator.
// Per-channel datapath lives in cic_lane; the top owns the shared control
// (sample counter, ratio/shift latch, dump pipeline strobes).
// Optional build macro CIC_SAT_FLAG_EN adds sticky per-channel saturation
// flags on port o_sat (bit0 = I, bit1 = Q).

module cic_lane #(
    parameter int IW = 32,
    parameter int OW = 16,
    parameter int AW = 56
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          ce_i,
    input  logic          snap_en_i,
    input  logic          comb_en_i,
    input  logic          out_en_i,
    input  logic [5:0]    shift_i,
    input  logic [IW-1:0] x_i,
`ifdef CIC_SAT_FLAG_EN
    output logic          sat_hit_o,
`endif
    output logic [OW-1:0] y_o
);
    localparam logic        [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] SMAX = (ONE << (OW - 1)) - ONE;
    localparam logic signed [AW:0] SMIN = ~SMAX;

    logic signed [AW-1:0] i1_q, i2_q, i3_q;
    logic signed [AW-1:0] s_q, s_dq, c1_dq, c2_dq, c3_q;
    logic signed [AW-1:0] c1, c2, c3;
    logic signed [AW-1:0] x_ext;
    logic signed [AW:0]   rnd_w, sum_w, shr_w;
    logic                 sat_hi, sat_lo;
    logic [OW-1:0]        y_d, y_q;

    assign x_ext = {{(AW-IW){x_i[IW-1]}}, x_i};

    // Integrators: wrap-around accumulation, advancing only on input strobes
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            i1_q <= '0;
            i2_q <= '0;
            i3_q <= '0;
        end else if (ce_i) begin
            i1_q <= i1_q + x_ext;
            i2_q <= i2_q + i1_q;
            i3_q <= i3_q + i2_q;
        end
    end

    // Snapshot of the last integrator one cycle after the window closes
    always_ff @(posedge clk_i) begin
        if (reset_i)
            s_q <= '0;
        else if (snap_en_i)
            s_q <= i3_q;
    end

    // Comb differences are chained within one cycle; delays move only on dumps
    assign c1 = s_q - s_dq;
    assign c2 = c1 - c1_dq;
    assign c3 = c2 - c2_dq;

    // Comb delay line and comb result register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s_dq  <= '0;
            c1_dq <= '0;
            c2_dq <= '0;
            c3_q  <= '0;
        end else if (comb_en_i) begin
            s_dq  <= s_q;
            c1_dq <= c1;
            c2_dq <= c2;
            c3_q  <= c3;
        end
    end

    // Round half up, arithmetic shift, then clamp to the output range.
    // One extra bit keeps the rounding add from overflowing.
    always_comb begin
        rnd_w = '0;
        sum_w = '0;
        if (int'(shift_i) >= AW) begin
            shr_w = {(AW+1){c3_q[AW-1]}};
        end else begin
            rnd_w = (shift_i == 6'd0) ? '0 : (ONE << (shift_i - 6'd1));
            sum_w = {c3_q[AW-1], c3_q} + rnd_w;
            shr_w = sum_w >>> shift_i;
        end
        sat_hi = (shr_w > SMAX);
        sat_lo = (shr_w < SMIN);
        if (sat_hi)
            y_d = SMAX[OW-1:0];
        else if (sat_lo)
            y_d = SMIN[OW-1:0];
        else
            y_d = shr_w[OW-1:0];
    end

    // Output register holds between strobes
    always_ff @(posedge clk_i) begin
        if (reset_i)
            y_q <= '0;
        else if (out_en_i)
            y_q <= y_d;
    end

    assign y_o = y_q;
`ifdef CIC_SAT_FLAG_EN
    assign sat_hit_o = sat_hi | sat_lo;
`endif
endmodule

module iq_cic_decim #(
    parameter int IW = 32,
    parameter int OW = 16,
    parameter int RW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_signal_i,
    input  logic signed [IW-1:0] i_signal_q,
    input  logic [RW-1:0]        i_decim,
    input  logic [5:0]           i_shift,
    output logic signed [OW-1:0] o_signal_i,
    output logic signed [OW-1:0] o_signal_q,
`ifdef CIC_SAT_FLAG_EN
    output logic [1:0]           o_sat,
`endif
    output logic                 o_valid
);
    localparam int AW        = IW + 3 * RW;
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 4;

    logic [RW-1:0]  cnt_q, cnt_d, r_decim_q;
    logic [5:0]     r_shift_q;
    logic           dump_w;
    logic [STAGES:1]      vld_pipe_q;
    logic [STAGES-1:1][5:0] sh_pipe_q;

    logic [NUM_LANES-1:0][IW-1:0] x_lanes;
    logic [NUM_LANES-1:0][OW-1:0] y_lanes;

    assign dump_w = i_ce && (cnt_q == r_decim_q);
    assign cnt_d  = dump_w ? '0 : cnt_q + 1'b1;

    // Sample counter; ratio and shift reload only at window boundaries
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q     <= '0;
            r_decim_q <= i_decim;
            r_shift_q <= i_shift;
        end else if (i_ce) begin
            cnt_q <= cnt_d;
            if (dump_w) begin
                r_decim_q <= i_decim;
                r_shift_q <= i_shift;
            end
        end
    end

    // Dump strobe pipeline: snapshot, comb, scale, valid.
    // The window's own shift travels with its strobe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_pipe_q <= '0;
            sh_pipe_q  <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], dump_w};
            sh_pipe_q  <= {sh_pipe_q[STAGES-2:1], r_shift_q};
        end
    end

    assign x_lanes[0] = i_signal_i;
    assign x_lanes[1] = i_signal_q;

`ifdef CIC_SAT_FLAG_EN
    logic [NUM_LANES-1:0] sat_hit;
    logic [1:0]           sat_q;

    // Sticky clamp flags, sampled alongside the output register load
    always_ff @(posedge i_clk) begin
        if (i_reset)
            sat_q <= '0;
        else if (vld_pipe_q[3])
            sat_q <= sat_q | sat_hit;
    end

    assign o_sat = sat_q;
`endif

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        cic_lane #(.IW(IW), .OW(OW), .AW(AW)) u_lane (
            .clk_i     (i_clk),
            .reset_i   (i_reset),
            .ce_i      (i_ce),
            .snap_en_i (vld_pipe_q[1]),
            .comb_en_i (vld_pipe_q[2]),
            .out_en_i  (vld_pipe_q[3]),
            .shift_i   (sh_pipe_q[3]),
            .x_i       (x_lanes[g]),
`ifdef CIC_SAT_FLAG_EN
            .sat_hit_o (sat_hit[g]),
`endif
            .y_o       (y_lanes[g])
        );
    end

    assign o_signal_i = y_lanes[0];
    assign o_signal_q = y_lanes[1];
    assign o_valid    = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_iq_cic_decim.sv
// Directed bench for iq_cic_decim with a behavioural CIC scoreboard.
module tb_iq_cic_decim;
    localparam int IW = 32;
    localparam int OW = 16;
    localparam int RW = 8;
    localparam int AW = IW + 3 * RW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ce;
    logic signed [IW-1:0] xi, xq;
    logic [RW-1:0]        decim;
    logic [5:0]           shift;
    logic signed [OW-1:0] yi, yq;
    logic                 vld;
`ifdef CIC_SAT_FLAG_EN
    logic [1:0]           sat;
`endif

    always #5 clk = ~clk;

    iq_cic_decim #(.IW(IW), .OW(OW), .RW(RW)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_ce       (ce),
        .i_signal_i (xi),
        .i_signal_q (xq),
        .i_decim    (decim),
        .i_shift    (shift),
        .o_signal_i (yi),
        .o_signal_q (yq),
`ifdef CIC_SAT_FLAG_EN
        .o_sat      (sat),
`endif
        .o_valid    (vld)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct { longint i; longint q; } exp_t;
    exp_t sbq[$];

    logic signed [AW-1:0] mi1[2], mi2[2], mi3[2], msd[2], mc1d[2], mc2d[2];
    logic [RW-1:0]        mcnt, mdec;
    logic [5:0]           msh;

    function automatic longint scale(input logic signed [AW-1:0] c, input logic [5:0] sh);
        longint v;
        longint one = 1;
        if (int'(sh) >= AW) begin
            v = (c < 0) ? -1 : 0;
        end else begin
            v = longint'(c);
            if (sh > 0) v = v + (one << (sh - 1));
            v = v >>> sh;
        end
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v;
    endfunction

    always @(posedge clk) begin
        logic signed [AW-1:0] xe, s, c1, c2, c3;
        longint r[2];
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                mi1[c] = '0; mi2[c] = '0; mi3[c] = '0;
                msd[c] = '0; mc1d[c] = '0; mc2d[c] = '0;
            end
            mcnt = '0;
            mdec = decim;
            msh  = shift;
            sbq.delete();
        end else if (ce) begin
            for (int c = 0; c < 2; c++) begin
                xe = (c == 0) ? xi : xq;
                mi3[c] = mi3[c] + mi2[c];
                mi2[c] = mi2[c] + mi1[c];
                mi1[c] = mi1[c] + xe;
            end
            if (mcnt == mdec) begin
                for (int c = 0; c < 2; c++) begin
                    s  = mi3[c];
                    c1 = s - msd[c];
                    c2 = c1 - mc1d[c];
                    c3 = c2 - mc2d[c];
                    msd[c] = s; mc1d[c] = c1; mc2d[c] = c2;
                    r[c] = scale(c3, msh);
                end
                sbq.push_back('{i: r[0], q: r[1]});
                mcnt = '0;
                mdec = decim;
                msh  = shift;
            end else begin
                mcnt = mcnt + 1'b1;
            end
        end
    end

    // Monitor: every strobe must match the oldest expected sample
    longint last_i, last_q;
    always @(negedge clk) begin
        exp_t e;
        if (vld === 1'b1) begin
            last_i = yi;
            last_q = yq;
            ncmp++;
            assert (sbq.size() != 0) else begin
                nerr++;
                $error("FAIL sb_underflow: observed strobe with %0d expected entries", sbq.size());
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("sb_i", yi, e.i);
                check("sb_q", yq, e.q);
            end
        end
    end

    // Toggles ce every cycle while enabled
    bit tog = 1'b0;
    always @(negedge clk) if (tog) ce = ~ce;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clocks until the next strobe, bounded
    task automatic wait_valid(input string tag, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vld !== 1'b1 && n < maxc);
        if (vld !== 1'b1) begin
            ncmp++;
            nerr++;
            $error("FAIL %s: no strobe within %0d clocks", tag, maxc);
        end
    endtask

    initial begin
        int n, cnt;
        rst = 1'b1; ce = 1'b0; xi = '0; xq = '0; decim = '0; shift = '0;
        cyc(3);
        check("rst_valid", vld, 0);
        check("rst_i", yi, 0);
        check("rst_q", yq, 0);
`ifdef CIC_SAT_FLAG_EN
        check("rst_sat", sat, 0);
`endif
        rst = 1'b0;

        // Pass-through: R=1, shift 0
        ce = 1'b1; xi = 1000; xq = -1000;
        cyc(5);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vld === 1'b1) cnt++;
        end
        check("pt_valid_cnt", cnt, 10);
        check("pt_i", last_i, 1000);
        check("pt_q", last_q, -1000);

        // DC gain: R=4, shift 6
        decim = 3; shift = 6; xi = 100; xq = -100;
        cyc(40);
        check("dc_i", last_i, 100);
        check("dc_q", last_q, -100);
        wait_valid("dc_sync", 10, n);
        wait_valid("dc_gap", 10, n);
        check("dc_spacing", n, 4);

        // Saturation, then input back to zero
        shift = 0; xi = 1000; xq = -1000;
        cyc(40);
        check("sat_i", last_i, 32767);
        check("sat_q", last_q, -32768);
`ifdef CIC_SAT_FLAG_EN
        check("sat_flag", sat, 3);
`endif
        xi = 0; xq = 0;
        cyc(40);
        check("zero_i", last_i, 0);
        check("zero_q", last_q, 0);
`ifdef CIC_SAT_FLAG_EN
        check("sat_sticky", sat, 3);
`endif

        // Rounding: R=2, shift 4
        decim = 1; shift = 4; xi = 3; xq = -3;
        cyc(40);
        check("rnd_pos", last_i, 2);
        check("rnd_neg", last_q, -1);

        // ce gaps, then ratio change mid-window
        decim = 3; shift = 6; xi = 100; xq = -100; tog = 1'b1;
        cyc(60);
        check("gap_i", last_i, 100);
        check("gap_q", last_q, -100);
        wait_valid("gap_sync", 20, n);
        wait_valid("gap_gap", 20, n);
        check("gap_spacing", n, 8);
        cyc(2);
        decim = 1;
        wait_valid("chg_old", 20, n);
        check("chg_old_window", n, 6);
        wait_valid("chg_new", 20, n);
        check("chg_new_window", n, 4);
        cyc(30);
        check("chg_i", last_i, 13);
        check("chg_q", last_q, -12);
        tog = 1'b0;
        @(negedge clk);

        // Reset mid-window
        rst = 1'b1; ce = 1'b0; decim = 3; shift = 6;
        cyc(1);
        rst = 1'b0; ce = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_valid", vld, 0);
        check("mid_rst_i", yi, 0);
        check("mid_rst_q", yq, 0);
        rst = 1'b0;
        wait_valid("mid_first", 20, n);
        check("mid_first_latency", n, 7);

        ce = 1'b0;
        cyc(10);
        check("sb_drain", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
